// File: rtl/seq_emitter.sv
// Frame transmitter for the 1-2-3 sequence detector: emits bursts of 1,2,3..3 frames
// separated by a 0 gap symbol, with a programmable hold on symbol 3.
module seq_emitter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] hold_len,
  input  logic [CNT_W-1:0] frames,
  output logic [1:0]       num,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    StIdle,
    StSym1,
    StSym2,
    StSym3,
    StGap
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] frm_cnt_q, frm_cnt_d;
  logic [CNT_W-1:0] hold_len_q, hold_len_d;
  logic [1:0]       num_q, num_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic last_sym3;
  logic more_frames;

  assign last_sym3   = (state_q == StSym3) && (hold_cnt_q == '0);
  assign more_frames = (frm_cnt_q > CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      frm_cnt_q  <= '0;
      hold_len_q <= '0;
      num_q      <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      frm_cnt_q  <= frm_cnt_d;
      hold_len_q <= hold_len_d;
      num_q      <= num_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    frm_cnt_d  = frm_cnt_q;
    hold_len_d = hold_len_q;
    done_d     = 1'b0;

    if (abort) begin
      // Abort cancels any burst; in idle it also suppresses a coincident start.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            hold_len_d = hold_len;
            hold_cnt_d = hold_len;
            frm_cnt_d  = (frames == '0) ? CNT_W'(1) : frames;
            state_d    = StSym1;
          end
        end
        StSym1: state_d = StSym2;
        StSym2: state_d = StSym3;
        StSym3: begin
          if (hold_cnt_q != '0) begin
            hold_cnt_d = hold_cnt_q - CNT_W'(1);
          end else if (more_frames) begin
            frm_cnt_d  = frm_cnt_q - CNT_W'(1);
            hold_cnt_d = hold_len_q;
            state_d    = StGap;
          end else begin
            state_d = StIdle;
          end
        end
        StGap:   state_d = StSym1;
        default: state_d = StIdle;
      endcase
    end

    if (!abort && last_sym3 && !more_frames) begin
      done_d = 1'b1;
    end
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    num_d  = 2'b00;
    busy_d = (state_d != StIdle);
    unique case (state_d)
      StSym1:  num_d = 2'b01;
      StSym2:  num_d = 2'b10;
      StSym3:  num_d = 2'b11;
      default: num_d = 2'b00;
    endcase
  end

  assign num  = num_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_emitter.sv
// Scoreboard bench for seq_emitter: expected {num,busy,done} per cycle is queued when a
// burst is launched and compared cycle by cycle at the falling edge.
module tb_seq_emitter;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] hold_len;
  logic [CNT_W-1:0] frames;
  logic [1:0]       num;
  logic             busy;
  logic             done;

  int unsigned n_vec;
  int unsigned n_err;

  logic [3:0] exp_q[$];
  logic [3:0] last_e;

  seq_emitter #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .hold_len (hold_len),
    .frames   (frames),
    .num      (num),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] ent(input int s, input bit b, input bit d);
    logic [1:0] s2;
    s2 = s[1:0];
    return {s2, b, d};
  endfunction

  task automatic push_burst(input int h, input int f);
    int fe;
    fe = (f == 0) ? 1 : f;
    for (int fr = 0; fr < fe; fr++) begin
      exp_q.push_back(ent(1, 1'b1, 1'b0));
      exp_q.push_back(ent(2, 1'b1, 1'b0));
      for (int k = 0; k <= h; k++) exp_q.push_back(ent(3, 1'b1, 1'b0));
      if (fr < fe - 1) exp_q.push_back(ent(0, 1'b1, 1'b0));
    end
    exp_q.push_back(ent(0, 1'b0, 1'b1));
  endtask

  // Advance one cycle and compare against the oldest queued expectation.
  task automatic step(input string tag);
    logic [3:0] e;
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({tag, "_underrun"}, 32'd1, 32'd0);
      e = ent(0, 1'b0, 1'b0);
    end else begin
      e = exp_q.pop_front();
    end
    check({tag, "_num"}, 32'(num), 32'(e[3:2]));
    check({tag, "_busy"}, 32'(busy), 32'(e[1]));
    check({tag, "_done"}, 32'(done), 32'(e[0]));
    last_e = e;
  endtask

  // Launch a burst and drain it; in noisy mode start and the config inputs toggle while busy.
  task automatic run_burst(input string tag, input int h, input int f, input bit noisy);
    hold_len = CNT_W'(h);
    frames   = CNT_W'(f);
    start    = 1'b1;
    push_burst(h, f);
    while (exp_q.size() > 0) begin
      step(tag);
      start = 1'b0;
      if (noisy && last_e[1]) begin
        start    = 1'($urandom_range(0, 1));
        hold_len = CNT_W'($urandom_range(0, 15));
        frames   = CNT_W'($urandom_range(0, 15));
      end
    end
    start = 1'b0;
    exp_q.push_back(ent(0, 1'b0, 1'b0));
    step({tag, "_idle"});
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    hold_len = '0;
    frames   = '0;
    last_e   = '0;
    repeat (2) @(negedge clk);
    check("rst_num", 32'(num), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    exp_q.push_back(ent(0, 1'b0, 1'b0));
    step("post_rst");

    run_burst("single", 0, 1, 1'b0);
    run_burst("long", 3, 2, 1'b0);
    run_burst("zero_frm", 15, 0, 1'b0);
    run_burst("noisy", 2, 3, 1'b1);

    // Abort during the second cycle of symbol 3.
    hold_len = 4'd3;
    frames   = 4'd1;
    start    = 1'b1;
    exp_q.push_back(ent(1, 1'b1, 1'b0));
    exp_q.push_back(ent(2, 1'b1, 1'b0));
    exp_q.push_back(ent(3, 1'b1, 1'b0));
    exp_q.push_back(ent(3, 1'b1, 1'b0));
    step("abort_pre");
    start = 1'b0;
    repeat (3) step("abort_pre");
    abort = 1'b1;
    exp_q.push_back(ent(0, 1'b0, 1'b0));
    step("abort_now");
    abort = 1'b0;
    exp_q.push_back(ent(0, 1'b0, 1'b0));
    step("abort_post");
    run_burst("after_abort", 1, 1, 1'b0);

    // Abort and start together in idle: abort wins.
    abort = 1'b1;
    start = 1'b1;
    exp_q.push_back(ent(0, 1'b0, 1'b0));
    step("abort_idle");
    abort = 1'b0;
    start = 1'b0;

    // Start held high through done: second burst follows with one idle cycle.
    begin
      bit first_done;
      first_done = 1'b0;
      hold_len = 4'd2;
      frames   = 4'd1;
      start    = 1'b1;
      push_burst(2, 1);
      push_burst(2, 1);
      while (exp_q.size() > 0) begin
        step("b2b");
        if (first_done) start = 1'b0;
        if (last_e[0]) first_done = 1'b1;
      end
      start = 1'b0;
      exp_q.push_back(ent(0, 1'b0, 1'b0));
      step("b2b_idle");
    end

    // Asynchronous reset in the middle of SYM2.
    hold_len = 4'd2;
    frames   = 4'd1;
    start    = 1'b1;
    exp_q.push_back(ent(1, 1'b1, 1'b0));
    step("arst_pre");
    start = 1'b0;
    @(posedge clk);
    #2;
    check("arst_sym2", 32'(num), 32'd2);
    reset = 1'b1;
    #1;
    check("arst_num", 32'(num), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(ent(0, 1'b0, 1'b0));
    step("arst_idle");
    run_burst("after_arst", 1, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_emitter.md
Name: seq_emitter

Overview:
- Pattern transmitter that drives the 2-bit symbol stream consumed by the 1-2-3 sequence detector.
- On a start request it emits one or more frames. Each frame is 1, 2, then 3 held for a programmable number of cycles, and frames are separated by a 0 gap symbol.
- Used as the stimulus source for the detector and as the symbol source in the practice top level.
- Sits upstream of the detector on the same clk domain, with num wired directly to the detector's num input.

Parameters:
CNT_W, 4, width of hold_len, frames and the internal counters

Ports:
clk       input   1      system clock, all state changes on posedge
reset     input   1      asynchronous, active-high; clears all state immediately
start     input   1      request to begin a burst; sampled only in IDLE
abort     input   1      synchronous cancel; wins over every other condition except reset
hold_len  input   CNT_W  extra cycles of symbol 3 after the first 3; latched at start
frames    input   CNT_W  number of frames in the burst; 0 is treated as 1; latched at start
num       output  2      emitted symbol, registered
busy      output  1      high in every state except IDLE
done      output  1      one-cycle pulse after the last symbol of a completed burst

Behaviour:
- Reset (async): state=IDLE, num=2'b00, busy=0, done=0, counters=0. Deassertion takes effect on the next posedge.
- All outputs are registered and decoded from state: IDLE→0, SYM1→1, SYM2→2, SYM3→3, GAP→0.
- IDLE:
  - start=1 → latch hold_len into hold_cnt and frames into frm_cnt (0 becomes 1); go to SYM1.
  - Latency: num=1 appears in the cycle after the start edge.
  - start=0 → stay in IDLE.
- SYM1 → SYM2 unconditionally, for one cycle.
- SYM2 → SYM3 unconditionally, for one cycle.
- SYM3: stays for hold_len+1 cycles total; hold_cnt decrements each cycle it is nonzero. When hold_cnt==0:
  - frm_cnt>1 → decrement frm_cnt, reload hold_cnt from the latched hold_len, go to GAP.
  - frm_cnt==1 → go to IDLE and set done=1 for that first IDLE cycle.
- GAP → SYM1, for one cycle. The 0 guarantees a detector returns to its start state between frames.
- Frame length is hold_len+3 cycles. Burst length is frames*(hold_len+4)-1 cycles.
- start is ignored while busy=1; no queuing.
- hold_len and frames changes during a burst have no effect. The latched copies are used.
- abort=1 in any non-IDLE state → IDLE on the next edge with num=0 and no done pulse. abort in IDLE is a no-op.
- abort and start both high in IDLE → abort wins; stay IDLE.
- done=1 only in the single cycle after the final SYM3 cycle; otherwise 0.
- start sampled high in that done cycle starts a new burst, so back-to-back bursts run with exactly one IDLE cycle between them.
- Counter boundary values:
  - hold_len=0 → exactly one 3 per frame.
  - hold_len=2^CNT_W-1 → 2^CNT_W threes. No wrap, because the counter only decrements to 0.
- Reset asserted mid-burst → immediate IDLE, num=0, busy=0, done=0, asynchronously without waiting for clk.
- Downstream contract: a detector fed by num raises ans for hold_len+1 consecutive cycles per frame, starting one cycle after the first 3.

Test Plan:
- Single frame: reset, then start=1 for one cycle with hold_len=0 and frames=1.
  - num: 1,2,3 then 0.
  - busy high for 3 cycles.
  - done pulses in cycle 4.
  - Detector ans high for exactly 1 cycle.
- Long hold: hold_len=3, frames=2.
  - num: 1,2,3,3,3,3,0,1,2,3,3,3,3 then 0.
  - done in cycle 14.
  - Detector ans high for 4 cycles twice, with a 3-cycle gap.
- Zero frames and saturation: frames=0 → behaves as frames=1. hold_len=15 → 16 consecutive 3s, then done.
- Abort: abort=1 during the second SYM3 cycle of hold_len=3.
  - Next cycle: num=0, busy=0.
  - done never asserts.
  - A start 2 cycles later runs a clean frame.
- Ignore and back-to-back:
  - start pulsed while busy → no effect on the sequence.
  - start held high through done → a second burst begins with num=1 in the cycle after done.
- Async reset mid-frame: assert reset between clock edges during SYM2 → num=0 and busy=0 before the next posedge. After release, the next start produces a normal frame.
